// File: rtl/ahb_word_mover_if.sv
// Command and AHB-lite bus bundle for ahb_word_mover.
// master = the engine side, slave = the controller/bus-slave side.
interface ahb_word_mover_if;
  logic        I_START;
  logic        I_MODE;
  logic [11:0] I_SRC_ADDR;
  logic [11:0] I_DST_ADDR;
  logic [9:0]  I_LEN;
  logic [31:0] I_FILL_DATA;
  logic        O_BUSY;
  logic        O_DONE;
  logic        O_ERR;
  logic [11:0] O_HADDR;
  logic [1:0]  O_HTRANS;
  logic        O_HWRITE;
  logic [2:0]  O_HSIZE;
  logic [2:0]  O_HBURST;
  logic [3:0]  O_HPROT;
  logic        O_HMASTLOCK;
  logic [31:0] O_HWDATA;
  logic [31:0] I_HRDATA;
  logic        I_HREADY;
  logic        I_HRESP;

  modport master (
    input  I_START, I_MODE, I_SRC_ADDR, I_DST_ADDR, I_LEN, I_FILL_DATA,
    input  I_HRDATA, I_HREADY, I_HRESP,
    output O_BUSY, O_DONE, O_ERR,
    output O_HADDR, O_HTRANS, O_HWRITE, O_HSIZE, O_HBURST, O_HPROT, O_HMASTLOCK, O_HWDATA
  );

  modport slave (
    output I_START, I_MODE, I_SRC_ADDR, I_DST_ADDR, I_LEN, I_FILL_DATA,
    output I_HRDATA, I_HREADY, I_HRESP,
    input  O_BUSY, O_DONE, O_ERR,
    input  O_HADDR, O_HTRANS, O_HWRITE, O_HSIZE, O_HBURST, O_HPROT, O_HMASTLOCK, O_HWDATA
  );
endinterface

// File: rtl/ahb_word_mover.sv
// AHB-lite single-master engine that fills or copies blocks of 32-bit words
// in a 4 KB window; word-aligned SINGLE/NONSEQ transfers only.
module ahb_word_mover (
  input  logic             I_HCLK,
  input  logic             I_HRESETn,
  ahb_word_mover_if.master bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_FLUSH, S_ERR
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  state_t      state;
  logic [9:0]  haddr_w;
  logic [9:0]  src_w;
  logic [9:0]  dst_w;
  logic [9:0]  remaining;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] fill_data;
  logic [31:0] copy_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        unused_addr_lsbs;

  // Addresses are kept as word indices; 10-bit arithmetic gives the 4 KB wrap.
  assign bus.O_HADDR     = {haddr_w, 2'b00};
  assign bus.O_HTRANS    = htrans;
  assign bus.O_HWRITE    = hwrite;
  assign bus.O_HWDATA    = hwdata;
  assign bus.O_HSIZE     = 3'b010;
  assign bus.O_HBURST    = 3'b000;
  assign bus.O_HPROT     = 4'b0011;
  assign bus.O_HMASTLOCK = 1'b0;
  assign bus.O_BUSY      = busy;
  assign bus.O_DONE      = done;
  assign bus.O_ERR       = err;
  assign dbg_state       = state;
  assign unused_addr_lsbs = ^{bus.I_SRC_ADDR[1:0], bus.I_DST_ADDR[1:0]};

  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) begin
      state     <= S_IDLE;
      haddr_w   <= '0;
      src_w     <= '0;
      dst_w     <= '0;
      remaining <= '0;
      htrans    <= HT_IDLE;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      fill_data <= '0;
      copy_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && state != S_ERR && bus.I_HRESP) begin
        // First ERROR cycle cancels any pending address; the second ends the command.
        htrans <= HT_IDLE;
        if (bus.I_HREADY) state <= S_ERR;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.I_START) begin
              src_w     <= bus.I_SRC_ADDR[11:2];
              dst_w     <= bus.I_DST_ADDR[11:2];
              remaining <= bus.I_LEN;
              fill_data <= bus.I_FILL_DATA;
              err       <= 1'b0;
              if (bus.I_LEN == 10'd0) begin
                done <= 1'b1;
              end else begin
                busy   <= 1'b1;
                htrans <= HT_NONSEQ;
                if (bus.I_MODE) begin
                  haddr_w <= bus.I_SRC_ADDR[11:2];
                  hwrite  <= 1'b0;
                  state   <= S_RD_A;
                end else begin
                  haddr_w <= bus.I_DST_ADDR[11:2];
                  hwrite  <= 1'b1;
                  state   <= S_FILL;
                end
              end
            end
          end
          S_FILL: begin
            // Each accepted address starts its data phase while the next address goes out.
            if (bus.I_HREADY) begin
              hwdata    <= fill_data;
              remaining <= remaining - 10'd1;
              if (remaining == 10'd1) begin
                htrans <= HT_IDLE;
                state  <= S_FLUSH;
              end else begin
                haddr_w <= haddr_w + 10'd1;
              end
            end
          end
          S_FLUSH: begin
            if (bus.I_HREADY) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_RD_A: begin
            if (bus.I_HREADY) begin
              htrans <= HT_IDLE;
              src_w  <= src_w + 10'd1;
              state  <= S_RD_D;
            end
          end
          S_RD_D: begin
            if (bus.I_HREADY) begin
              copy_data <= bus.I_HRDATA;
              htrans    <= HT_NONSEQ;
              haddr_w   <= dst_w;
              hwrite    <= 1'b1;
              state     <= S_WR_A;
            end
          end
          S_WR_A: begin
            if (bus.I_HREADY) begin
              htrans <= HT_IDLE;
              hwdata <= copy_data;
              dst_w  <= dst_w + 10'd1;
              state  <= S_WR_D;
            end
          end
          S_WR_D: begin
            if (bus.I_HREADY) begin
              remaining <= remaining - 10'd1;
              if (remaining == 10'd1) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                htrans  <= HT_NONSEQ;
                haddr_w <= src_w;
                hwrite  <= 1'b0;
                state   <= S_RD_A;
              end
            end
          end
          S_ERR: begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_word_mover.sv
// Directed bench for ahb_word_mover: an SRAM-like AHB slave with wait/error
// injection, an expected-transfer queue and an expected-done queue.
`timescale 1ns/1ps
module tb_ahb_word_mover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] dbg_state;

  ahb_word_mover_if bus();

  ahb_word_mover dut (
    .I_HCLK    (clk),
    .I_HRESETn (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // {hwrite, haddr, wdata} per completed data phase; {err, absolute done cycle}
  logic [44:0] exp_q[$];
  logic [32:0] done_q[$];

  logic [31:0] mem [1024];

  // Slave configuration, written only by the stimulus process
  int wr_waits   = 0;
  int rd_waits   = 0;
  int err_target = -1;

  // Slave / monitor state
  logic        dp_valid, dp_write, dp_err;
  logic [11:0] dp_addr;
  int          wait_left, err_stage, wr_seq;
  logic        prev_ready, prev_resp, prev_write;
  logic [1:0]  prev_trans;
  logic [11:0] prev_addr;
  logic [31:0] prev_wdata;
  logic        fin, fin_err;
  logic [44:0] e;
  logic [32:0] d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus"}, 64'({bus.O_HTRANS, bus.O_HADDR, bus.O_HWRITE, bus.O_HWDATA}), 64'(0));
    check({tag, "_status"}, 64'({bus.O_BUSY, bus.O_DONE, bus.O_ERR}), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  // Slave responder and scoreboard monitor, evaluated on the falling edge
  initial begin
    bus.I_HREADY = 1'b1;
    bus.I_HRESP  = 1'b0;
    bus.I_HRDATA = '0;
    dp_valid = 1'b0; dp_write = 1'b0; dp_err = 1'b0; dp_addr = '0;
    wait_left = 0; err_stage = 0; wr_seq = 0;
    prev_ready = 1'b1; prev_resp = 1'b0; prev_write = 1'b0;
    prev_trans = 2'b00; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp_valid = 1'b0; err_stage = 0; wait_left = 0; wr_seq = 0;
        bus.I_HREADY = 1'b1; bus.I_HRESP = 1'b0;
        prev_ready = 1'b1; prev_resp = 1'b0;
        continue;
      end
      if (!bus.O_BUSY) wr_seq = 0;

      if (!prev_ready && !prev_resp) begin
        if (prev_trans == 2'b10)
          check("addr_ctrl_hold", 64'({bus.O_HTRANS, bus.O_HWRITE, bus.O_HADDR}),
                64'({prev_trans, prev_write, prev_addr}));
        if (dp_valid && dp_write)
          check("hwdata_hold", 64'(bus.O_HWDATA), 64'(prev_wdata));
      end

      if (bus.O_DONE) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d[31:0]));
          check("done_err", 64'(bus.O_ERR), 64'(d[32]));
          check("busy_at_done", 64'(bus.O_BUSY), 64'(0));
        end
      end

      fin = 1'b0; fin_err = 1'b0;
      if (!dp_valid) begin
        bus.I_HREADY = 1'b1; bus.I_HRESP = 1'b0;
      end else if (err_stage == 1) begin
        bus.I_HREADY = 1'b1; bus.I_HRESP = 1'b1; err_stage = 2;
        check("htrans_idle_err", 64'(bus.O_HTRANS), 64'(0));
        fin = 1'b1; fin_err = 1'b1;
      end else if (dp_err) begin
        bus.I_HREADY = 1'b0; bus.I_HRESP = 1'b1; err_stage = 1;
      end else if (wait_left > 0) begin
        bus.I_HREADY = 1'b0; bus.I_HRESP = 1'b0; wait_left--;
      end else begin
        bus.I_HREADY = 1'b1; bus.I_HRESP = 1'b0; fin = 1'b1;
      end

      if (fin) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got write=%0b addr=%03h, expected none", dp_write, dp_addr);
        end else begin
          e = exp_q.pop_front();
          check("xfer_dir_addr", 64'({dp_write, dp_addr}), 64'(e[44:32]));
          if (dp_write) check("xfer_wdata", 64'(bus.O_HWDATA), 64'(e[31:0]));
        end
        if (dp_write && !fin_err) mem[dp_addr[11:2]] = bus.O_HWDATA;
        else if (!dp_write) bus.I_HRDATA = mem[dp_addr[11:2]];
      end

      if (bus.I_HREADY) begin
        if (err_stage == 2) err_stage = 0;
        dp_valid  = (bus.O_HTRANS == 2'b10);
        dp_write  = bus.O_HWRITE;
        dp_addr   = bus.O_HADDR;
        dp_err    = 1'b0;
        wait_left = bus.O_HWRITE ? wr_waits : rd_waits;
        if (dp_valid && dp_write) begin
          if (wr_seq == err_target) dp_err = 1'b1;
          wr_seq++;
        end
      end

      prev_ready = bus.I_HREADY;
      prev_resp  = bus.I_HRESP;
      prev_trans = bus.O_HTRANS;
      prev_write = bus.O_HWRITE;
      prev_addr  = bus.O_HADDR;
      prev_wdata = bus.O_HWDATA;
    end
  end

  task automatic push_w(input logic [11:0] addr, input logic [31:0] data);
    exp_q.push_back({1'b1, addr, data});
  endtask

  task automatic push_r(input logic [11:0] addr);
    exp_q.push_back({1'b0, addr, 32'h0});
  endtask

  // Issue one command and wait (bounded) for its completion pulse.
  task automatic run_cmd(input logic mode, input logic [11:0] src, input logic [11:0] dst,
                         input logic [9:0] len, input logic [31:0] fill,
                         input int rel_done, input logic exp_err, input logic poke);
    int c;
    int n;
    @(negedge clk);
    bus.I_MODE = mode; bus.I_SRC_ADDR = src; bus.I_DST_ADDR = dst;
    bus.I_LEN = len; bus.I_FILL_DATA = fill; bus.I_START = 1'b1;
    c = cyc;
    done_q.push_back({exp_err, 32'(c + rel_done)});
    @(negedge clk);
    bus.I_START = 1'b0;
    if (len != 10'd0) check("busy_cycle1", 64'(bus.O_BUSY), 64'(1));
    if (poke) begin
      bus.I_START = 1'b1; bus.I_MODE = ~mode; bus.I_LEN = 10'd9;
      bus.I_DST_ADDR = 12'h800; bus.I_FILL_DATA = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.I_START = 1'b0;
    end
    n = 0;
    while (done_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within 400 cycles, expected done");
      done_q.delete();
    end
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.I_START = 1'b0; bus.I_MODE = 1'b0; bus.I_SRC_ADDR = '0;
    bus.I_DST_ADDR = '0; bus.I_LEN = '0; bus.I_FILL_DATA = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[12'h100 >> 2] = 32'hC0DE_0100;
    mem[12'h104 >> 2] = 32'hC0DE_0104;
    mem[12'h108 >> 2] = 32'hC0DE_0108;

    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    check("const_ctrl", 64'({bus.O_HSIZE, bus.O_HBURST, bus.O_HPROT, bus.O_HMASTLOCK}),
          64'({3'b010, 3'b000, 4'b0011, 1'b0}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill 4 words, zero wait
    for (int i = 0; i < 4; i++) push_w(12'h010 + 12'(4 * i), 32'hA5A5_0001);
    run_cmd(1'b0, 12'h000, 12'h010, 10'd4, 32'hA5A5_0001, 6, 1'b0, 1'b0);

    // Copy 3 words with one write wait state
    wr_waits = 1;
    for (int i = 0; i < 3; i++) begin
      push_r(12'h100 + 12'(4 * i));
      push_w(12'h200 + 12'(4 * i), 32'hC0DE_0100 + 32'(4 * i));
    end
    run_cmd(1'b1, 12'h100, 12'h200, 10'd3, 32'h0, 16, 1'b0, 1'b0);
    wr_waits = 0;

    // Read back the filled word through a one-word copy
    push_r(12'h010);
    push_w(12'h300, 32'hA5A5_0001);
    run_cmd(1'b1, 12'h013, 12'h302, 10'd1, 32'h0, 5, 1'b0, 1'b0);

    // Fill wrapping past the top of the window
    push_w(12'hFF8, 32'h1234_5678);
    push_w(12'hFFC, 32'h1234_5678);
    push_w(12'h000, 32'h1234_5678);
    run_cmd(1'b0, 12'h000, 12'hFF8, 10'd3, 32'h1234_5678, 5, 1'b0, 1'b0);

    // Fill with two wait states per data phase: addresses held while stalled
    wr_waits = 2;
    for (int i = 0; i < 3; i++) push_w(12'h080 + 12'(4 * i), 32'h0F0F_F0F0);
    run_cmd(1'b0, 12'h000, 12'h080, 10'd3, 32'h0F0F_F0F0, 11, 1'b0, 1'b0);
    wr_waits = 0;

    // ERROR on the second fill write
    err_target = 1;
    push_w(12'h040, 32'h5555_AAAA);
    push_w(12'h044, 32'h5555_AAAA);
    run_cmd(1'b0, 12'h000, 12'h040, 10'd4, 32'h5555_AAAA, 6, 1'b1, 1'b0);
    err_target = -1;

    // LEN=0 after the error: no transfers, done next cycle, O_ERR cleared
    run_cmd(1'b0, 12'h000, 12'h040, 10'd0, 32'h0, 1, 1'b0, 1'b0);

    // START pulsed while busy is ignored
    push_w(12'h0C0, 32'h7777_0000);
    push_w(12'h0C4, 32'h7777_0000);
    run_cmd(1'b0, 12'h000, 12'h0C0, 10'd2, 32'h7777_0000, 4, 1'b0, 1'b1);

    // Reset in the middle of a copy
    for (int i = 0; i < 3; i++) begin
      push_r(12'h100 + 12'(4 * i));
      push_w(12'h240 + 12'(4 * i), 32'hC0DE_0100 + 32'(4 * i));
    end
    @(negedge clk);
    bus.I_MODE = 1'b1; bus.I_SRC_ADDR = 12'h100; bus.I_DST_ADDR = 12'h240;
    bus.I_LEN = 10'd3; bus.I_START = 1'b1;
    @(negedge clk);
    bus.I_START = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midcopy_reset");
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh copy after reset completes normally
    for (int i = 0; i < 3; i++) begin
      push_r(12'h100 + 12'(4 * i));
      push_w(12'h240 + 12'(4 * i), 32'hC0DE_0100 + 32'(4 * i));
    end
    run_cmd(1'b1, 12'h100, 12'h240, 10'd3, 32'h0, 13, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_word_mover.md
# ahb_word_mover

AHB-lite single-master transfer engine that fills or copies blocks of 32-bit words in the 4 KB SRAM window. It sits directly upstream of the single-port SRAM bridge and drives its AHB-lite slave port. A local controller supplies the command through a start/busy/done interface. The engine issues word-only (HSIZE=WORD), single (HBURST=SINGLE), NONSEQ transfers and honours HREADY wait states and two-cycle ERROR responses.

## Interface
- No parameters. Address width is fixed at 12 bits, data width at 32, word count at 10 bits.
- I_HCLK  in  1  clock; all logic is rising-edge.
- I_HRESETn  in  1  reset, asynchronous, active-low.
- I_START  in  1  command strobe; sampled only when O_BUSY=0.
- I_MODE  in  1  0=fill, 1=copy.
- I_SRC_ADDR  in  12  copy source byte address; bits[1:0] ignored.
- I_DST_ADDR  in  12  destination byte address; bits[1:0] ignored.
- I_LEN  in  10  word count, 0..1023.
- I_FILL_DATA  in  32  fill pattern.
- O_BUSY  out  1  command in progress.
- O_DONE  out  1  one-cycle completion pulse.
- O_ERR  out  1  sticky; set on ERROR response, cleared by accepted START.
- O_HADDR  out  12  AHB address; bits[1:0] always 00.
- O_HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- O_HWRITE  out  1  transfer direction.
- O_HSIZE  out  3  constant 3'b010.
- O_HBURST  out  3  constant 3'b000.
- O_HPROT  out  4  constant 4'b0011.
- O_HMASTLOCK  out  1  constant 0.
- O_HWDATA  out  32  write data, driven in the data phase.
- I_HRDATA  in  32  read data.
- I_HREADY  in  1  transfer-complete / bus-ready.
- I_HRESP  in  1  0=OKAY, 1=ERROR.

## Operation
- States: IDLE, FILL, RD_A, RD_D, WR_A, WR_D, FLUSH, ERR.
- IDLE: START=1 latches the addresses (word-aligned), LEN, FILL_DATA and MODE; clears O_ERR; sets O_BUSY.
  - LEN=0: stay in IDLE with no bus activity, pulse O_DONE on the next cycle.
  - Otherwise go to FILL (mode 0) or RD_A (mode 1).
- FILL: pipelined writes. The address phase of word n+1 overlaps the data phase of word n, and O_HWDATA=fill pattern in every data phase. After the last address phase is accepted, go to FLUSH.
- FLUSH: HTRANS=IDLE until the final data phase completes (HREADY=1), then return to IDLE and pulse O_DONE.
- Copy, per word:
  - RD_A: NONSEQ read at the source address.
  - RD_D: HTRANS=IDLE; on HREADY=1 capture I_HRDATA into the copy register.
  - WR_A: NONSEQ write at the destination address.
  - WR_D: HTRANS=IDLE; O_HWDATA=copy register; on HREADY=1 decrement the remaining count, then go to RD_A, or to IDLE with O_DONE if the count has reached zero.
- Address increment is +4 per word, modulo 4096; 0xFFC wraps to 0x000 without error.
- HREADY=0 during any address phase: hold O_HADDR, O_HTRANS, O_HWRITE and all control stable. HREADY=0 during any data phase: hold O_HWDATA stable.
- ERROR response:
  - First cycle (HRESP=1, HREADY=0): drive HTRANS=IDLE, which cancels any pipelined fill address.
  - Second cycle (HRESP=1, HREADY=1): enter ERR.
  - ERR: set O_ERR, pulse O_DONE, return to IDLE. No further transfers.
- START while O_BUSY=1 is ignored.

## Timing
- Reset values:
  - O_HTRANS=00, O_HADDR=0, O_HWRITE=0, O_HWDATA=0.
  - O_BUSY=0, O_DONE=0, O_ERR=0.
  - All internal registers 0, state IDLE.
- Reset mid-command aborts immediately with no completion pulse.
- All outputs are registered, except the constant HSIZE, HBURST, HPROT and HMASTLOCK.
- START sampled at edge 0 → first address phase in cycle 1.
- Fill, zero wait: address phases in cycles 1..LEN, data phases in cycles 2..LEN+1, O_DONE in cycle LEN+2, O_BUSY falls with O_DONE.
- Copy, zero wait: 4 cycles per word, O_DONE in cycle 4·LEN+1.
- Each HREADY-low cycle adds exactly one cycle to the affected phase.
- O_DONE is high for exactly one cycle, in the same cycle O_BUSY deasserts; a new START is accepted in that same cycle.

## Test plan
- Fill, DST=0x010, LEN=4, pattern 0xA5A5_0001, HREADY always 1 → writes to 0x010, 0x014, 0x018, 0x01C in consecutive cycles; O_DONE in cycle 6; readback returns 0xA5A5_0001.
- Copy, SRC=0x100, DST=0x200, LEN=3, with the SRAM bridge as slave (one write wait state) → words at 0x200..0x208 equal 0x100..0x108; address, control and HWDATA stay stable during every HREADY-low cycle.
- Fill, DST=0xFF8, LEN=3 → addresses 0xFF8, 0xFFC, 0x000; O_ERR=0.
- ERROR response on the second fill write → HTRANS=IDLE in the first ERROR cycle, no third address phase, O_ERR=1, single O_DONE pulse; the next START clears O_ERR.
- LEN=0 START → no NONSEQ cycle, O_DONE the next cycle. START pulsed while busy → ignored, and the transfer count stays as originally commanded.
- I_HRESETn asserted mid-copy → all outputs return to reset values asynchronously, with no O_DONE; a fresh command after release completes normally.
